// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data BRAM between the CPU memory path and a DMA/debug requester.
// AMO sequences hold lock so no DMA access can land between their read and write phases.
module data_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int ADDR_W       = 32,
  parameter int MAX_DMA_WAIT = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cpu_req,
  input  logic [XLEN/8-1:0]   i_cpu_we,
  input  logic [ADDR_W-1:0]   i_cpu_addr,
  input  logic [XLEN-1:0]     i_cpu_wdata,
  input  logic                i_cpu_lock,
  output logic                o_cpu_stall,
  output logic                o_cpu_rvalid,
  output logic [XLEN-1:0]     o_cpu_rdata,
  input  logic                i_dma_valid,
  input  logic [XLEN/8-1:0]   i_dma_we,
  input  logic [ADDR_W-1:0]   i_dma_addr,
  input  logic [XLEN-1:0]     i_dma_wdata,
  output logic                o_dma_ready,
  output logic                o_dma_rvalid,
  output logic [XLEN-1:0]     o_dma_rdata,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [XLEN/8-1:0]   o_mem_we,
  output logic [XLEN-1:0]     o_mem_wdata,
  input  logic [XLEN-1:0]     i_mem_rdata,
  output logic                o_lock_active
);

  localparam int WB = XLEN / 8;
  localparam int CW = $clog2(MAX_DMA_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_DMA_WAIT);

  typedef struct packed {
    logic [WB-1:0]     we;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
  } mem_req_t;

  typedef enum logic {UNLOCKED, LOCKED} lock_e;
  typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_DMA} rd_e;

  lock_e          state_q, state_d;
  rd_e            rd_owner_q, rd_owner_d;
  logic [CW-1:0]  wait_cnt;
  logic           lock_now, dma_gnt, cpu_gnt;
  mem_req_t       cpu_req, dma_req, mem_req;

  assign cpu_req = '{we: i_cpu_we, addr: i_cpu_addr, wdata: i_cpu_wdata};
  assign dma_req = '{we: i_dma_we, addr: i_dma_addr, wdata: i_dma_wdata};

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= UNLOCKED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: if (i_cpu_lock)  state_d = LOCKED;
      LOCKED:   if (!i_cpu_lock) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  // Lock is checked before DMA so an AMO starting alongside a DMA request keeps the port.
  always_comb begin
    lock_now   = i_cpu_lock || (state_q == LOCKED);
    dma_gnt    = 1'b0;
    cpu_gnt    = 1'b0;
    mem_req    = cpu_req;
    rd_owner_d = RD_NONE;
    if (!i_rst) begin
      if (lock_now)
        cpu_gnt = i_cpu_req;
      else if (i_dma_valid && (!i_cpu_req || wait_cnt == WAIT_MAX))
        dma_gnt = 1'b1;
      else
        cpu_gnt = i_cpu_req;
    end
    if (dma_gnt) begin
      mem_req = dma_req;
      if (i_dma_we == '0) rd_owner_d = RD_DMA;
    end else if (cpu_gnt) begin
      if (i_cpu_we == '0) rd_owner_d = RD_CPU;
    end else begin
      mem_req.we = '0;
    end
  end

  // Saturating starvation counter; it keeps running under lock so DMA wins the first free cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_dma_valid || dma_gnt) wait_cnt <= '0;
    else if (wait_cnt != WAIT_MAX)        wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) rd_owner_q <= RD_NONE;
    else       rd_owner_q <= rd_owner_d;
  end

  assign o_dma_ready   = dma_gnt;
  assign o_cpu_stall   = i_cpu_req && dma_gnt;
  assign o_mem_addr    = mem_req.addr;
  assign o_mem_we      = mem_req.we;
  assign o_mem_wdata   = mem_req.wdata;
  assign o_cpu_rdata   = i_mem_rdata;
  assign o_dma_rdata   = i_mem_rdata;
  assign o_cpu_rvalid  = !i_rst && (rd_owner_q == RD_CPU);
  assign o_dma_rvalid  = !i_rst && (rd_owner_q == RD_DMA);
  assign o_lock_active = (state_q == LOCKED);

endmodule
